cfg_sched: RTL
==============

# cfg_sched

Configuration scheduler for the camera register-write path. It shares one I2C word-write engine between two requesters: a boot sequence replayed from a register table ROM, and a runtime user port for exposure/gain updates. It arbitrates between them, issues transactions, and retries a transaction when the engine reports a NACK. It sits between the register table/user logic and the I2C write engine.

## Interface
- BOOT_LEN, 16: number of boot table entries, legal range 1..256
- MAX_RETRY, 3: re-issues allowed after a NACK, 0..7
- GAP, 4: idle cycles inserted after every transaction, 1..15
- clk2  in  1  system clock, all logic on posedge
- reset  in  1  asynchronous, active-low
- boot_go  in  1  pulse; starts boot replay from entry 0
- rom_addr  out  8  boot table address
- rom_data  in  24  {reg[7:0], data[15:0]}, valid 1 cycle after rom_addr
- usr_req  in  1  user write request, held until usr_ack
- usr_reg  in  8  user register address, stable while usr_req is high
- usr_data  in  16  user write data, stable while usr_req is high
- usr_ack  out  1  1-cycle pulse; request fields latched
- usr_done  out  1  1-cycle pulse; user transaction finished
- usr_err  out  1  valid with usr_done; 1 means dropped after retries
- eng_start  out  1  1-cycle pulse; engine begins a word write
- eng_reg  out  8  register address, held from ISSUE until done
- eng_data  out  16  write data, held from ISSUE until done
- eng_busy  in  1  engine is mid-transaction
- eng_done  in  1  1-cycle pulse at end of transaction
- eng_nack  in  1  valid with eng_done; 1 means the slave did not ACK
- boot_busy  out  1  boot replay pending or active
- boot_done  out  1  1-cycle pulse after the last boot entry
- cfg_err  out  1  sticky; any transaction dropped; cleared by reset or boot_go

## Operation
- Registered state: state, boot_idx[7:0] (drives rom_addr), retry_cnt[2:0], gap_cnt[3:0], last_grant (0 = boot, 1 = user), src (owner of the current transaction), boot_pend.
- Reset values:
  - All outputs are 0: rom_addr, eng_reg, eng_data, usr_ack, usr_done, usr_err, eng_start, boot_busy, boot_done, cfg_err.
  - Internal: state = IDLE, last_grant = 1, boot_pend = 0.
- boot_go when boot_pend = 0: set boot_pend, set boot_idx = 0, clear cfg_err. boot_go when boot_pend = 1 is ignored. boot_busy = boot_pend.
- IDLE:
  - If boot_pend and (usr_req = 0 or last_grant = 1): go to FETCH, src = boot.
  - Else if usr_req: latch usr_reg/usr_data into eng_reg/eng_data, src = user, pulse usr_ack next cycle, go to ISSUE.
  - Net effect: round-robin alternation when both requesters are pending.
- FETCH: rom_addr is stable; go to LOAD.
- LOAD: latch rom_data[23:16] into eng_reg and rom_data[15:0] into eng_data; go to ISSUE.
- ISSUE:
  - If eng_busy = 0: eng_start = 1 for this cycle, then go to WAIT.
  - If eng_busy = 1: hold in ISSUE with eng_start = 0.
- WAIT: hold until eng_done.
  - eng_nack = 0: success.
  - eng_nack = 1 and retry_cnt < MAX_RETRY: retry_cnt + 1, go to GAP, then back to ISSUE.
  - eng_nack = 1 and retry_cnt = MAX_RETRY: fail; set cfg_err.
- Completion (success or fail):
  - retry_cnt is cleared and last_grant = src.
  - If src = boot: boot_idx + 1. If boot_idx was BOOT_LEN-1: boot_pend = 0, boot_done pulses, boot_idx stays 8-bit with no wrap use.
  - If src = user: usr_done pulses, usr_err = fail.
  - Then go to GAP and return to IDLE.
- A failed boot entry is skipped; the sequence continues with the next entry.
- GAP: count GAP cycles, then go to the next state.
- eng_done outside WAIT is ignored.
- Reset mid-transaction returns everything to reset values immediately. The engine shares the same reset.

## Timing
- Boot entry: FETCH at cycle t, LOAD at t+1, eng_start at t+2 when the engine is idle.
- User request: usr_req sampled in IDLE at edge k. usr_ack and eng_start are both high in cycle k+1.
- usr_done, usr_err, boot_done and cfg_err update one cycle after the eng_done edge.
- Between a transaction's eng_done and the next eng_start: at least GAP+1 cycles.
- usr_req held high after usr_ack is treated as a new request.

## Test plan
- BOOT_LEN=4, all ACK, boot_go pulse:
  - rom_addr steps 0,1,2,3; four eng_start pulses carry ROM contents.
  - boot_done pulses once; boot_busy falls; cfg_err = 0.
- Idle controller, usr_req with reg 0x09, data 0x0400:
  - usr_ack one cycle later, coincident with eng_start with eng_reg = 0x09, eng_data = 0x0400.
  - usr_done with usr_err = 0.
- Boot active, usr_req raised during entry 1: grant order boot0, boot1, user, boot2, boot3.
- Entry 2 NACKs twice with MAX_RETRY=3: three eng_start pulses for entry 2, no cfg_err, boot completes.
- User write NACKs 4 times with MAX_RETRY=3:
  - 4 starts, then usr_done with usr_err = 1; cfg_err = 1.
  - A later boot_go clears cfg_err.
- Reset asserted in WAIT: all outputs 0 asynchronously. After release, boot_go replays from rom_addr 0.

Source files
------------

// File: rtl/cfg_sched.sv
// Configuration write scheduler: shares one I2C word-write engine between boot-table
// replay and runtime user writes, with round-robin grant, NACK retry and a post-transaction gap.
module cfg_sched #(
  parameter int BOOT_LEN  = 16,
  parameter int MAX_RETRY = 3,
  parameter int GAP       = 4
) (
  input  logic        clk2,
  input  logic        reset,
  input  logic        boot_go,
  output logic [7:0]  rom_addr,
  input  logic [23:0] rom_data,
  input  logic        usr_req,
  input  logic [7:0]  usr_reg,
  input  logic [15:0] usr_data,
  output logic        usr_ack,
  output logic        usr_done,
  output logic        usr_err,
  output logic        eng_start,
  output logic [7:0]  eng_reg,
  output logic [15:0] eng_data,
  input  logic        eng_busy,
  input  logic        eng_done,
  input  logic        eng_nack,
  output logic        boot_busy,
  output logic        boot_done,
  output logic        cfg_err
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_ISSUE, S_WAIT, S_GAP} state_e;
  typedef enum logic {SRC_BOOT = 1'b0, SRC_USR = 1'b1} src_e;

  state_e      state_q, state_d;
  logic [7:0]  boot_idx_q, boot_idx_d;
  logic [2:0]  retry_cnt_q, retry_cnt_d;
  logic [3:0]  gap_cnt_q, gap_cnt_d;
  src_e        last_grant_q, last_grant_d;
  src_e        src_q, src_d;
  logic        boot_pend_q, boot_pend_d;
  logic [7:0]  eng_reg_q, eng_reg_d;
  logic [15:0] eng_data_q, eng_data_d;
  logic        usr_ack_q, usr_ack_d;
  logic        usr_done_q, usr_done_d;
  logic        usr_err_q, usr_err_d;
  logic        boot_done_q, boot_done_d;
  logic        cfg_err_q, cfg_err_d;

  logic grant_boot, grant_usr, wait_done, do_retry, do_complete, do_fail, last_entry, boot_start;

  // Boot wins a tie unless it was also the previous owner, giving alternation under contention.
  assign grant_boot  = (state_q == S_IDLE) && boot_pend_q && (!usr_req || (last_grant_q == SRC_USR));
  assign grant_usr   = (state_q == S_IDLE) && !grant_boot && usr_req;
  assign wait_done   = (state_q == S_WAIT) && eng_done;
  assign do_retry    = wait_done && eng_nack && (retry_cnt_q < 3'(MAX_RETRY));
  assign do_complete = wait_done && !do_retry;
  assign do_fail     = do_complete && eng_nack;
  assign last_entry  = (boot_idx_q == 8'(BOOT_LEN - 1));
  assign boot_start  = boot_go && !boot_pend_q;

  always_ff @(posedge clk2 or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (grant_boot)     state_d = S_FETCH;
        else if (grant_usr) state_d = S_ISSUE;
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD:  state_d = S_ISSUE;
      S_ISSUE: if (!eng_busy) state_d = S_WAIT;
      S_WAIT:  if (eng_done) state_d = S_GAP;
      // A nonzero retry count means the gap precedes a re-issue rather than the next grant.
      S_GAP:   if (gap_cnt_q == 4'd0) state_d = (retry_cnt_q != 3'd0) ? S_ISSUE : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    eng_start = (state_q == S_ISSUE) && !eng_busy;
  end

  always_comb begin
    boot_idx_d   = boot_idx_q;
    retry_cnt_d  = retry_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    last_grant_d = last_grant_q;
    src_d        = src_q;
    boot_pend_d  = boot_pend_q;
    eng_reg_d    = eng_reg_q;
    eng_data_d   = eng_data_q;
    usr_ack_d    = grant_usr;
    usr_done_d   = 1'b0;
    usr_err_d    = 1'b0;
    boot_done_d  = 1'b0;
    cfg_err_d    = cfg_err_q;

    if (boot_start) begin
      boot_pend_d = 1'b1;
      boot_idx_d  = 8'd0;
      cfg_err_d   = 1'b0;
    end

    if (grant_boot) src_d = SRC_BOOT;
    if (grant_usr) begin
      src_d      = SRC_USR;
      eng_reg_d  = usr_reg;
      eng_data_d = usr_data;
    end
    if (state_q == S_LOAD) begin
      eng_reg_d  = rom_data[23:16];
      eng_data_d = rom_data[15:0];
    end

    if ((state_q == S_GAP) && (gap_cnt_q != 4'd0)) gap_cnt_d = gap_cnt_q - 4'd1;
    if (wait_done) gap_cnt_d = 4'(GAP - 1);
    if (do_retry)  retry_cnt_d = retry_cnt_q + 3'd1;

    if (do_complete) begin
      retry_cnt_d  = 3'd0;
      last_grant_d = src_q;
      if (do_fail) cfg_err_d = 1'b1;
      if (src_q == SRC_BOOT) begin
        boot_idx_d = boot_idx_q + 8'd1;
        if (last_entry) begin
          boot_pend_d = 1'b0;
          boot_done_d = 1'b1;
        end
      end else begin
        usr_done_d = 1'b1;
        usr_err_d  = do_fail;
      end
    end
  end

  always_ff @(posedge clk2 or negedge reset) begin
    if (!reset) begin
      boot_idx_q   <= 8'd0;
      retry_cnt_q  <= 3'd0;
      gap_cnt_q    <= 4'd0;
      last_grant_q <= SRC_USR;
      src_q        <= SRC_BOOT;
      boot_pend_q  <= 1'b0;
      eng_reg_q    <= 8'd0;
      eng_data_q   <= 16'd0;
      usr_ack_q    <= 1'b0;
      usr_done_q   <= 1'b0;
      usr_err_q    <= 1'b0;
      boot_done_q  <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      boot_idx_q   <= boot_idx_d;
      retry_cnt_q  <= retry_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      last_grant_q <= last_grant_d;
      src_q        <= src_d;
      boot_pend_q  <= boot_pend_d;
      eng_reg_q    <= eng_reg_d;
      eng_data_q   <= eng_data_d;
      usr_ack_q    <= usr_ack_d;
      usr_done_q   <= usr_done_d;
      usr_err_q    <= usr_err_d;
      boot_done_q  <= boot_done_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign rom_addr  = boot_idx_q;
  assign eng_reg   = eng_reg_q;
  assign eng_data  = eng_data_q;
  assign usr_ack   = usr_ack_q;
  assign usr_done  = usr_done_q;
  assign usr_err   = usr_err_q;
  assign boot_busy = boot_pend_q;
  assign boot_done = boot_done_q;
  assign cfg_err   = cfg_err_q;

endmodule
